alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Decode/issue stage that turns a fetched RV32I instruction and its register-file read data into the operand, control and funct3 bundle consumed by the execute-stage ALU. It is the producing end of the ALU control interface. It contains one registered pipeline stage (the ID/EX register) with valid/ready handshaking, stall and flush. It sits between the register file read port and the execute-stage ALU.

## Interface
- D_WIDTH, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- instr  in  32  RV32I instruction word.
- pc  in  D_WIDTH  address of instr.
- rs1_data, rs2_data  in  D_WIDTH  register-file read data for instr[19:15] and instr[24:20].
- flush  in  1  discard the held instruction and any instruction accepted this cycle.
- out_valid  out  1  EX bundle valid.
- out_ready  in  1  EX consumes the bundle.
- aluop1, aluop2  out  D_WIDTH  ALU operands.
- aluctrl  out  4  ALU operation code.
- funct3  out  3  instr[14:12], passed through for the branch comparator.
- is_branch, is_jump, mem_read, mem_write, reg_write  out  1  control flags.
- rd  out  5  destination register.
- store_data  out  D_WIDTH  rs2_data, used for stores.
- illegal  out  1  instruction not decodable (see Configuration).

## Operation
- aluctrl encoding:
  - add 0000, sub 0001, and 0010, or 0011, xor 0100
  - slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001
- OP (0110011):
  - aluop1=rs1_data, aluop2={27'b0, rs2_data[4:0]} for shifts, rs2_data otherwise.
  - funct7[5] selects sub (funct3 000) and sra (funct3 101).
  - reg_write=1.
- OP-IMM (0010011):
  - aluop2 is the sign-extended I-immediate.
  - For slli/srli/srai, aluop2={27'b0, instr[24:20]}; instr[30] selects srai.
  - funct3 000 is always add, never sub.
- LOAD/STORE: add rs1_data plus the sign-extended I- or S-immediate. Sets mem_read or mem_write; reg_write only for LOAD.
- LUI: aluop1=0, aluop2=U-immediate, add.
- AUIPC: aluop1=pc, aluop2=U-immediate, add.
- JAL/JALR: aluop1=pc, aluop2=4, add, is_jump=1, reg_write=1.
- BRANCH (1100011): aluop1=rs1_data, aluop2=rs2_data, aluctrl=sub, is_branch=1, reg_write=0. funct3 carries the condition.
- rd is forced to 0 when reg_write=0.

## Timing
- Latency is 1 cycle: an instruction accepted on edge N appears on the outputs after edge N.
- in_ready = !out_valid || out_ready (combinational). This gives full throughput with no bubble.
- A transfer occurs when in_valid && in_ready. Otherwise the outputs hold while out_valid && !out_ready.
- flush has priority:
  - On the next edge out_valid becomes 0.
  - An instruction accepted in the same cycle is dropped.
  - in_ready is forced to 1 during flush.
- Reset (asynchronous, any cycle, including mid-stall) sets every output register to 0: out_valid=0, aluctrl=0000, all flags 0, illegal=0.
- Output registers load only on a transfer. Data is held unchanged while stalled.

## Configuration
- ALU_DECODE_ILLEGAL_EN:
  - Defined: unknown opcode, or reserved funct3/funct7 combinations (for example OP with funct7 not in {0000000, 0100000}), set illegal=1 with the bundle. In that case reg_write, mem_read, mem_write, is_branch and is_jump are all 0 and aluctrl=0000.
  - Undefined: illegal is tied to 0. An unknown opcode decodes as a bubble (all flags 0, add), with out_valid still asserted.

## Structure
- A shared package holds:
  - the aluctrl enum (ALU_ADD … ALU_SRA, values as above), used by both this stage and the ALU;
  - the opcode localparams;
  - a packed struct for the EX bundle.
- One sub-module, imm_gen, is combinational: it builds the I/S/B/U/J immediates from instr.
- Decode is combinational in the top module. The pipeline register is in the top module.

## Test plan
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, aluctrl=0000, aluop1=5, aluop2=7, rd=3, reg_write=1.
- sub (0x402081B3), rs1=5, rs2=7 -> aluctrl=0001.
- srai x3,x1,4 (0x4040D193) -> aluctrl=1001, aluop2=4.
- sll x3,x1,x2 with rs2=0x23 -> aluop2=3.
- beq x1,x2,+8 (0x00208463) -> is_branch=1, funct3=000, aluctrl=0001, reg_write=0, rd=0.
- Backpressure and flush:
  - Hold out_ready=0 for 3 cycles with a new in_valid -> in_ready=0 and outputs unchanged.
  - Then assert flush -> out_valid=0 on the next edge.
- Pull rst_n low mid-stall -> all outputs 0 immediately.
- With ALU_DECODE_ILLEGAL_EN defined, 0xFFFFFFFF -> illegal=1 and all flags 0.

Source files
------------

// File: rtl/alu_decode_stage_pkg.sv
// Shared types for the decode stage and the execute-stage ALU: ALU operation
// codes, RV32I opcodes, the ID/EX bundle, and the funct3-to-ALU-op mapping.
package alu_decode_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } aluctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] aluop1;
    logic [XLEN-1:0] aluop2;
    aluctrl_e        aluctrl;
    logic [2:0]      funct3;
    logic            is_branch;
    logic            is_jump;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] store_data;
    logic            illegal;
  } ex_bundle_t;

  // alt picks sub for funct3 000 and sra for funct3 101; callers decide when alt is meaningful
  function automatic aluctrl_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode_stage_imm_gen.sv
// Combinational RV32I immediate builder: I, S, B, U and J formats, all
// sign-extended to 32 bits. Only instr[31:7] carries immediate bits.
module imm_gen (
  input  logic [31:7] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage feeding the EX ALU through one ID/EX register with
// valid/ready, stall and flush. Define ALU_DECODE_ILLEGAL_EN to flag undecodable words.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic [D_WIDTH-1:0] pc,
  input  logic [D_WIDTH-1:0] rs1_data,
  input  logic [D_WIDTH-1:0] rs2_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] aluop1,
  output logic [D_WIDTH-1:0] aluop2,
  output logic [3:0]         aluctrl,
  output logic [2:0]         funct3,
  output logic               is_branch,
  output logic               is_jump,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [4:0]         rd,
  output logic [D_WIDTH-1:0] store_data,
  output logic               illegal
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  ex_bundle_t  bundle_next;
  ex_bundle_t  bundle_reg;
  logic        valid_reg;
  logic        unused_imm;

  imm_gen u_imm_gen (
    .instr (instr[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  // Branch/jump targets are computed in EX from pc; B/J immediates are not part of this bundle
  assign unused_imm = ^{imm_b, imm_j};

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];

  always_comb begin
    bundle_next            = '0;
    bundle_next.aluctrl    = ALU_ADD;
    bundle_next.funct3     = f3;
    bundle_next.store_data = rs2_data;
    bundle_next.rd         = instr[11:7];
    case (opcode)
      OPC_OP: begin
        bundle_next.aluop1    = rs1_data;
        bundle_next.aluop2    = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, rs2_data[4:0]} : rs2_data;
        bundle_next.aluctrl   = alu_from_funct3(f3, instr[30]);
        bundle_next.reg_write = 1'b1;
`ifdef ALU_DECODE_ILLEGAL_EN
        if (!(instr[31:25] == 7'h00 ||
              (instr[31:25] == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))))
          bundle_next.illegal = 1'b1;
`endif
      end
      OPC_OP_IMM: begin
        bundle_next.aluop1    = rs1_data;
        bundle_next.aluop2    = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, instr[24:20]} : imm_i;
        // instr[30] is immediate data for addi, so only shifts-right may take the alternate op
        bundle_next.aluctrl   = alu_from_funct3(f3, (f3 == 3'b101) && instr[30]);
        bundle_next.reg_write = 1'b1;
`ifdef ALU_DECODE_ILLEGAL_EN
        if ((f3 == 3'b001 && instr[31:25] != 7'h00) ||
            (f3 == 3'b101 && instr[31:25] != 7'h00 && instr[31:25] != 7'h20))
          bundle_next.illegal = 1'b1;
`endif
      end
      OPC_LOAD: begin
        bundle_next.aluop1    = rs1_data;
        bundle_next.aluop2    = imm_i;
        bundle_next.mem_read  = 1'b1;
        bundle_next.reg_write = 1'b1;
`ifdef ALU_DECODE_ILLEGAL_EN
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
          bundle_next.illegal = 1'b1;
`endif
      end
      OPC_STORE: begin
        bundle_next.aluop1    = rs1_data;
        bundle_next.aluop2    = imm_s;
        bundle_next.mem_write = 1'b1;
`ifdef ALU_DECODE_ILLEGAL_EN
        if (f3[2] || f3 == 3'b011)
          bundle_next.illegal = 1'b1;
`endif
      end
      OPC_LUI: begin
        bundle_next.aluop2    = imm_u;
        bundle_next.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        bundle_next.aluop1    = pc;
        bundle_next.aluop2    = imm_u;
        bundle_next.reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // ALU produces the link value pc+4
        bundle_next.aluop1    = pc;
        bundle_next.aluop2    = 32'd4;
        bundle_next.is_jump   = 1'b1;
        bundle_next.reg_write = 1'b1;
`ifdef ALU_DECODE_ILLEGAL_EN
        if (opcode == OPC_JALR && f3 != 3'b000)
          bundle_next.illegal = 1'b1;
`endif
      end
      OPC_BRANCH: begin
        bundle_next.aluop1    = rs1_data;
        bundle_next.aluop2    = rs2_data;
        bundle_next.aluctrl   = ALU_SUB;
        bundle_next.is_branch = 1'b1;
`ifdef ALU_DECODE_ILLEGAL_EN
        if (f3 == 3'b010 || f3 == 3'b011)
          bundle_next.illegal = 1'b1;
`endif
      end
      default: begin
`ifdef ALU_DECODE_ILLEGAL_EN
        bundle_next.illegal = 1'b1;
`endif
      end
    endcase
`ifdef ALU_DECODE_ILLEGAL_EN
    if (bundle_next.illegal) begin
      bundle_next.aluctrl   = ALU_ADD;
      bundle_next.is_branch = 1'b0;
      bundle_next.is_jump   = 1'b0;
      bundle_next.mem_read  = 1'b0;
      bundle_next.mem_write = 1'b0;
      bundle_next.reg_write = 1'b0;
    end
`endif
    if (!bundle_next.reg_write)
      bundle_next.rd = 5'd0;
  end

  assign in_ready = flush || !valid_reg || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= 1'b0;
      bundle_reg <= '0;
    end else if (flush) begin
      valid_reg  <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_reg  <= 1'b1;
      bundle_reg <= bundle_next;
    end else if (out_ready) begin
      valid_reg  <= 1'b0;
    end
  end

  assign out_valid  = valid_reg;
  assign aluop1     = bundle_reg.aluop1;
  assign aluop2     = bundle_reg.aluop2;
  assign aluctrl    = bundle_reg.aluctrl;
  assign funct3     = bundle_reg.funct3;
  assign is_branch  = bundle_reg.is_branch;
  assign is_jump    = bundle_reg.is_jump;
  assign mem_read   = bundle_reg.mem_read;
  assign mem_write  = bundle_reg.mem_write;
  assign reg_write  = bundle_reg.reg_write;
  assign rd         = bundle_reg.rd;
  assign store_data = bundle_reg.store_data;
  assign illegal    = bundle_reg.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed-vector bench for alu_decode_stage: decode of each instruction class,
// backpressure, flush, and asynchronous reset during a stall.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [31:0] aluop1, aluop2, store_data;
  logic [3:0]  aluctrl;
  logic [2:0]  funct3;
  logic        is_branch, is_jump, mem_read, mem_write, reg_write, illegal;
  logic [4:0]  rd;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] op_instr [10];
  logic [3:0]  op_ctrl  [10];
  logic [31:0] op_src2  [10];

  alu_decode_stage #(.D_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .aluop1(aluop1), .aluop2(aluop2), .aluctrl(aluctrl), .funct3(funct3),
    .is_branch(is_branch), .is_jump(is_jump), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .rd(rd),
    .store_data(store_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk);
    instr = i; pc = p; rs1_data = r1; rs2_data = r2;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("instr=%08h pc=%08h rs1=%08h rs2=%08h -> v=%0b ctrl=%04b op1=%08h op2=%08h rd=%0d wr=%0b",
             i, p, r1, r2, out_valid, aluctrl, aluop1, aluop2, rd, reg_write);
  endtask

  initial begin
    op_instr = '{32'h002081B3, 32'h402081B3, 32'h002091B3, 32'h0020A1B3, 32'h0020B1B3,
                 32'h0020C1B3, 32'h0020D1B3, 32'h4020D1B3, 32'h0020E1B3, 32'h0020F1B3};
    op_ctrl  = '{4'h0, 4'h1, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h9, 4'h3, 4'h2};
    op_src2  = '{32'h27, 32'h27, 32'h07, 32'h27, 32'h27, 32'h27, 32'h07, 32'h07, 32'h27, 32'h27};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_ctrl", {28'b0, aluctrl}, 32'd0);
    check("rst_regwr", {31'b0, reg_write}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_ctrl", {28'b0, aluctrl}, 32'h0);
    check("add_op1", aluop1, 32'd5);
    check("add_op2", aluop2, 32'd7);
    check("add_rd", {27'b0, rd}, 32'd3);
    check("add_regwr", {31'b0, reg_write}, 32'd1);

    issue(32'h402081B3, 32'h0, 32'd5, 32'd7);
    check("sub_ctrl", {28'b0, aluctrl}, 32'h1);

    issue(32'h4040D193, 32'h0, 32'hF0000000, 32'd99);
    check("srai_ctrl", {28'b0, aluctrl}, 32'h9);
    check("srai_op2", aluop2, 32'd4);
    check("srai_op1", aluop1, 32'hF0000000);

    issue(32'h002091B3, 32'h0, 32'd1, 32'h23);
    check("sll_op2", aluop2, 32'd3);
    check("sll_ctrl", {28'b0, aluctrl}, 32'h7);

    for (int k = 0; k < 10; k++) begin
      issue(op_instr[k], 32'h0, 32'h11, 32'h27);
      check($sformatf("op%0d_ctrl", k), {28'b0, aluctrl}, {28'b0, op_ctrl[k]});
      check($sformatf("op%0d_op2", k), aluop2, op_src2[k]);
    end

    issue(32'h00208463, 32'h0, 32'd12, 32'd13);
    check("beq_branch", {31'b0, is_branch}, 32'd1);
    check("beq_f3", {29'b0, funct3}, 32'd0);
    check("beq_ctrl", {28'b0, aluctrl}, 32'h1);
    check("beq_regwr", {31'b0, reg_write}, 32'd0);
    check("beq_rd", {27'b0, rd}, 32'd0);
    check("beq_op2", aluop2, 32'd13);

    issue(32'hFFF08293, 32'h0, 32'd1, 32'd0);
    check("addi_neg_op2", aluop2, 32'hFFFFFFFF);
    issue(32'h40008293, 32'h0, 32'd1, 32'd0);
    check("addi_b30_ctrl", {28'b0, aluctrl}, 32'h0);
    check("addi_b30_op2", aluop2, 32'h400);

    issue(32'h0080A283, 32'h0, 32'h1000, 32'd0);
    check("lw_mrd", {31'b0, mem_read}, 32'd1);
    check("lw_regwr", {31'b0, reg_write}, 32'd1);
    check("lw_op2", aluop2, 32'd8);
    check("lw_f3", {29'b0, funct3}, 32'd2);

    issue(32'hFE20AE23, 32'h0, 32'h1000, 32'hCAFEF00D);
    check("sw_mwr", {31'b0, mem_write}, 32'd1);
    check("sw_regwr", {31'b0, reg_write}, 32'd0);
    check("sw_rd", {27'b0, rd}, 32'd0);
    check("sw_op2", aluop2, 32'hFFFFFFFC);
    check("sw_sdata", store_data, 32'hCAFEF00D);

    issue(32'h123453B7, 32'h0, 32'h55, 32'd0);
    check("lui_op1", aluop1, 32'd0);
    check("lui_op2", aluop2, 32'h12345000);
    check("lui_rd", {27'b0, rd}, 32'd7);

    issue(32'h00001397, 32'h100, 32'h55, 32'd0);
    check("auipc_op1", aluop1, 32'h100);
    check("auipc_op2", aluop2, 32'h1000);

    issue(32'h008000EF, 32'h200, 32'h55, 32'd0);
    check("jal_jump", {31'b0, is_jump}, 32'd1);
    check("jal_op1", aluop1, 32'h200);
    check("jal_op2", aluop2, 32'd4);
    check("jal_rd", {27'b0, rd}, 32'd1);
    @(posedge clk);
    #1;
    check("drain_valid", {31'b0, out_valid}, 32'd0);

    issue(32'hFFFFFFFF, 32'h0, 32'd1, 32'd2);
    check("unk_valid", {31'b0, out_valid}, 32'd1);
    check("unk_regwr", {31'b0, reg_write}, 32'd0);
    check("unk_flags", {28'b0, is_branch, is_jump, mem_read, mem_write}, 32'd0);
    check("unk_ctrl", {28'b0, aluctrl}, 32'd0);
`ifdef ALU_DECODE_ILLEGAL_EN
    check("unk_illegal", {31'b0, illegal}, 32'd1);
`else
    check("unk_illegal", {31'b0, illegal}, 32'd0);
`endif

    // Stall three cycles with a pending instruction, then flush
    issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h402081B3; rs1_data = 32'd9; rs2_data = 32'd11;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_ready", k), {31'b0, in_ready}, 32'd0);
      check($sformatf("stall%0d_valid", k), {31'b0, out_valid}, 32'd1);
      check($sformatf("stall%0d_ctrl", k), {28'b0, aluctrl}, 32'h0);
      check($sformatf("stall%0d_op1", k), aluop1, 32'd5);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_drop", aluop1, 32'd5);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // Asynchronous reset while stalled
    issue(32'h123453B7, 32'h0, 32'd0, 32'd0);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
    @(posedge clk);
    #1;
    check("rstall_held", aluop2, 32'h12345000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_op2", aluop2, 32'd0);
    check("arst_rd", {27'b0, rd}, 32'd0);
    check("arst_regwr", {31'b0, reg_write}, 32'd0);
    check("arst_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
